intcon: RTL
===========

# intcon

Interrupt controller sitting directly downstream of the protocol-controller container. It turns the 4-bit `int_sig` level vector (SPI DONE, UART RDDONE, UART WRDONE, I2C DONE) into latched, maskable, prioritised interrupt requests. It presents one request at a time to the core through a request/acknowledge/done handshake. Lines are captured on rising edges, so a long-held DONE level produces exactly one interrupt.

## Interface
- `NSRC`, 4: number of interrupt sources; fixed at 4 for this design; `irq_id` is 2 bits wide.
- `clk` in 1: system clock; all state updates on its rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `int_sig` in 4: source levels from the protocol-controller container, same clock domain; bit 3 = SPI DONE, bit 2 = UART RDDONE, bit 1 = UART WRDONE, bit 0 = I2C DONE.
- `en_wr` in 1: load `en_din` into the enable mask this cycle.
- `en_din` in 4: new enable mask.
- `clr_wr` in 1: clear pending bits selected by `clr_din`.
- `clr_din` in 4: pending-clear mask, 1 = clear.
- `irq` out 1: interrupt request to core; registered.
- `irq_id` out 2: index of the requested or in-service source; registered.
- `irq_ack` in 1: core has taken the interrupt; one-cycle pulse.
- `irq_done` in 1: core has finished the handler (mret); one-cycle pulse.
- `pending` out 4: pending register.
- `en_mask` out 4: enable register.
- `in_service` out 1: high while in SERV state.

## Operation
- Edge detect: `int_prev` registers `int_sig` every cycle. `rise = int_sig & ~int_prev`. Each `rise[i]` sets `pending[i]` whether or not bit `i` is enabled.
- Pending update priority per bit, highest first:
  1. Set by `rise`.
  2. Clear by FSM acknowledge of that id.
  3. Clear by `clr_wr & clr_din[i]`.
- Consequence of the priority order: a rise on the same bit in the same cycle as its clear leaves the bit set.
- `req = pending & en_mask`. Fixed priority: bit 3 is highest, bit 0 lowest. `sel` = index of the highest set bit of `req`.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if `req != 0`, go to REQ, set `irq <= 1` and `irq_id <= sel`. Otherwise stay.
  - REQ: `irq_id` stays frozen; a higher-priority arrival does not pre-empt it.
    - If `irq_ack`: clear `pending[irq_id]`, set `irq <= 0`, go to SERV, set `in_service <= 1`.
    - Else if `req[irq_id] == 0` (masked or cleared by software): withdraw; set `irq <= 0` and go to IDLE.
  - SERV: no new request is issued; pending bits keep accumulating. On `irq_done`: set `in_service <= 0` and go to IDLE. `irq_id` holds its last value.
- `irq_ack` outside REQ and `irq_done` outside SERV are ignored.
- `en_wr` takes effect at the clock edge. The new mask is used by the FSM from the following cycle.
- Reset (async, any state, mid-handshake included): all outputs and internal registers go to 0. This covers FSM=IDLE, `irq`=0, `irq_id`=0, `pending`=0, `en_mask`=0, `in_service`=0 and `int_prev`=0. If `int_sig` is already high when reset releases, that counts as a rise on the first clock.

## Timing
- `int_sig[i]` is first sampled high at edge k. `pending[i]`=1 after edge k.
- With bit `i` enabled and FSM in IDLE, `irq`=1 and `irq_id`=i after edge k+1. Source-to-irq latency is therefore 2 cycles.
- `irq_ack` sampled at edge m: `irq`=0, `in_service`=1 and `pending[irq_id]`=0 after edge m.
- `irq_done` sampled at edge n: IDLE after edge n. The next `irq` (if `req != 0`) comes after edge n+1.
- Back-to-back throughput: minimum 1 idle cycle between `irq_done` and the next `irq`.
- Withdraw: `req[irq_id]` falls at edge w. `irq`=0 after edge w+1, because `req` is evaluated from registered state.

## Test plan
- Reset then `en_mask`=4'hF. Pulse `int_sig`=4'b0001 high for 5 cycles. Required: `pending`=4'b0001 one edge later, `irq`=1 with `irq_id`=0 one edge after that, and only one interrupt despite the held level.
- `int_sig` rises on bits 0 and 3 in the same cycle. Required: `irq_id`=3 first. After ack and done, `irq_id`=0. `pending` goes 4'b1001 → 4'b0001 → 4'b0000.
- `en_mask`=4'b0000, rise on bit 2. Required: `pending`=4'b0100 and `irq` stays 0. Then write `en_mask`=4'b0100. Required: `irq`=1 with `irq_id`=2 two edges after the write.
- In REQ with `irq_id`=1, write `en_mask`=4'b0000 before ack. Required: `irq` drops, FSM returns to IDLE, `pending[1]` stays 1.
- In the same cycle as `irq_ack` for id 2, a new rise on bit 2. Required: `pending[2]` remains 1. After `irq_done`, `irq` reasserts with `irq_id`=2.
- Assert `nrst`=0 asynchronously mid-clock while in SERV with `pending`=4'b1010. Required: `irq`, `in_service`, `pending` and `en_mask` read 0 immediately, without waiting for a clock edge. A stray `irq_done` after release has no effect.

Source files
------------

// File: rtl/intcon.sv
// intcon: latched, maskable, fixed-priority interrupt controller.
// Rising edges on int_sig set pending bits. The enabled pending bits are
// offered to the core one at a time through an irq/ack/done handshake.
// Bit 3 has the highest priority and bit 0 the lowest.
module intcon #(
    parameter int NSRC = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [NSRC-1:0]         int_sig,
    input  logic                    en_wr,
    input  logic [NSRC-1:0]         en_din,
    input  logic                    clr_wr,
    input  logic [NSRC-1:0]         clr_din,
    output logic                    irq,
    output logic [$clog2(NSRC)-1:0] irq_id,
    input  logic                    irq_ack,
    input  logic                    irq_done,
    output logic [NSRC-1:0]         pending,
    output logic [NSRC-1:0]         en_mask,
    output logic                    in_service
);

    localparam int IDW = $clog2(NSRC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            irq_q, irq_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic            in_service_q, in_service_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] en_mask_q, en_mask_d;
    logic [NSRC-1:0] int_prev_q;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] req;
    logic [IDW-1:0]  sel;
    logic            ack_fire;

    assign rise     = int_sig & ~int_prev_q;
    assign req      = pending_q & en_mask_q;
    assign ack_fire = (state_q == ST_REQ) && irq_ack;

    // Per-bit pending update. A rise beats the acknowledge clear, and the
    // acknowledge clear beats the software clear. Because of this order, a
    // source that fires again while it is being acknowledged is not lost.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            always_comb begin
                pending_d[gi] = pending_q[gi];
                if (rise[gi]) begin
                    pending_d[gi] = 1'b1;
                end else if (ack_fire && (irq_id_q == IDW'(gi))) begin
                    pending_d[gi] = 1'b0;
                end else if (clr_wr && clr_din[gi]) begin
                    pending_d[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Enable mask load. The FSM sees the new mask only on the next cycle.
    always_comb begin
        en_mask_d = en_mask_q;
        if (en_wr) begin
            en_mask_d = en_din;
        end
    end

    // Fixed-priority encoder. The scan runs from bit 0 upwards, so the
    // highest set request bit overwrites the lower ones and wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (req[i]) begin
                sel = IDW'(i);
            end
        end
    end

    // Handshake FSM: next state and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = sel;
                end
            end
            ST_REQ: begin
                // irq_id stays frozen here. A higher-priority arrival does
                // not pre-empt the request that is already presented.
                if (irq_ack) begin
                    state_d      = ST_SERV;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                end else if (!req[irq_id_q]) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERV: begin
                if (irq_done) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // State register. Reset is asynchronous and clears everything, including
    // int_prev, so a level that is already high at release counts as a rise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            en_mask_q    <= '0;
            int_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            en_mask_q    <= en_mask_d;
            int_prev_q   <= int_sig;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign en_mask    = en_mask_q;

endmodule
